// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide unit that owns the HI/LO register pair.
// Shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
module mult_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Handshake: a start is accepted only in IDLE (busy=0) and is a one-cycle
    // pulse; busy then stays high until the edge that writes hi/lo, and done
    // pulses for exactly that one cycle with hi/lo already updated.
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t               state, state_next;
    logic                 op_div, sign_q, sign_r;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 load, dz_set, finish;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign busy     = (state != IDLE);
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, b_reg});
    // The remainder after a successful subtract is below the divisor, so W bits suffice.
    assign rem_sub  = rem_sh[WIDTH-1:0] - b_reg;
    assign prod_fix = sign_q ? -acc : acc;
    assign quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        dz_set     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!abort) begin
                    if (start_mult) begin
                        load       = 1'b1;
                        state_next = PREP;
                    end else if (start_div) begin
                        if (rt_val != '0) begin
                            load       = 1'b1;
                            state_next = PREP;
                        end else begin
                            dz_set = 1'b1;
                        end
                    end
                end
            end
            PREP: state_next = abort ? IDLE : RUN;
            RUN: begin
                if (abort)
                    state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                finish     = !abort;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= finish;
            div_zero <= dz_set;
            case (state)
                IDLE: begin
                    if (load) begin
                        op_div <= !start_mult;
                        acc    <= {{WIDTH{1'b0}}, rs_val};
                        b_reg  <= rt_val;
                    end
                end
                PREP: begin
                    sign_q <= acc[WIDTH-1] ^ b_reg[WIDTH-1];
                    sign_r <= acc[WIDTH-1];
                    acc    <= {{WIDTH{1'b0}}, mag(acc[WIDTH-1:0])};
                    b_reg  <= mag(b_reg);
                    cnt    <= '0;
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_div)
                        acc <= {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
                    else if (acc[0])
                        acc <= {add_sum, acc[WIDTH-1:1]};
                    else
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                end
                FIX: begin
                    if (finish) begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed corner cases plus random
// operations compared against a signed-arithmetic reference model.
module tb_mult_div_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start_mult, start_div, abort;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int           n_cmp;
    int           n_err;
    logic [W-1:0] m_hi, m_lo;
    logic [2*W-1:0] exp_q[$];

    mult_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .abort      (abort),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full signed product, or truncating signed divide with C-style remainder.
    function automatic logic [63:0] model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // kind: 0 mult, 1 div, 2 both starts. poke/abort_at: edge count after T, -1 for none.
    task automatic do_op(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int poke, input int abort_at);
        int        k;
        bit        busy_bad, done_seen;
        logic [63:0] e;
        @(negedge clk);
        rs_val     = a;
        rt_val     = b;
        start_mult = (kind != 1);
        start_div  = (kind != 0);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        if (kind == 1 && b == '0) begin
            check({tag, "_dz"}, div_zero, 1);
            check({tag, "_dz_busy"}, busy, 0);
            check({tag, "_dz_done"}, done, 0);
            @(negedge clk);
            check({tag, "_dz_pulse"}, div_zero, 0);
            check({tag, "_dz_hilo"}, {hi, lo}, {m_hi, m_lo});
            return;
        end
        check({tag, "_busy_start"}, busy, 1);
        if (abort_at < 0)
            exp_q.push_back(model(kind == 1, a, b));
        k = 0;
        busy_bad = 0;
        while (!done && k < 100) begin
            if (k == poke) begin
                start_mult = 1'b1;
                rs_val     = $urandom;
                rt_val     = $urandom;
            end
            abort = (k == abort_at);
            @(negedge clk);
            k++;
            start_mult = 1'b0;
            abort      = 1'b0;
            if (abort_at >= 0 && k == abort_at + 1) break;
            if (!done && !busy) busy_bad = 1;
        end
        if (abort_at >= 0) begin
            check({tag, "_abort_busy"}, busy, 0);
            done_seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) done_seen = 1;
                @(negedge clk);
            end
            check({tag, "_abort_done"}, done_seen, 0);
            check({tag, "_abort_hilo"}, {hi, lo}, {m_hi, m_lo});
            return;
        end
        check({tag, "_busy_hold"}, busy_bad, 0);
        check({tag, "_latency"}, k, 34);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 0);
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, e);
        {m_hi, m_lo} = e;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_hi = '0;
        m_lo = '0;
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        abort = 1'b0;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, div_zero, hi, lo}, 67'd0);
        reset = 1'b1;

        do_op(0, 32'd7, 32'hFFFF_FFFD, "mult_7_m3", -1, -1);
        check("mult_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", -1, -1);
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", -1, -1);
        check("div_7_m2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        do_op(1, 32'd5, 32'd0, "div_zero", -1, -1);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1, -1);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(0, 32'h8000_0000, 32'h8000_0000, "mult_min", -1, -1);
        check("mult_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(2, 32'd6, 32'd2, "both_start", -1, -1);
        check("both_start_const", {hi, lo}, 64'd12);
        do_op(0, 32'h1234_5678, 32'hFEDC_BA98, "mult_poke", 10, -1);
        do_op(1, 32'd1000, 32'd7, "div_abort", -1, 5);

        // abort together with a start in IDLE: nothing is launched
        @(negedge clk);
        start_mult = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start_mult = 1'b0;
        abort      = 1'b0;
        check("idle_abort_busy", busy, 0);

        // reset mid-divide clears everything at once
        @(negedge clk);
        rs_val = 32'd99999;
        rt_val = 32'd13;
        start_div = 1'b1;
        @(negedge clk);
        start_div = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, done, div_zero, hi, lo}, 67'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        do_op(0, 32'd3, 32'd4, "mult_3_4", -1, -1);
        check("mult_3_4_const", {hi, lo}, 64'd12);

        for (int i = 0; i < 12; i++) begin
            int          kind;
            logic [W-1:0] a, b;
            kind = $urandom_range(0, 1);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            do_op(kind, a, b, $sformatf("rand%0d", i), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
